mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the instruction-fetch requester and the load/store data requester of the ARMv4 core.
- Sequences each access as a request/acknowledge transaction and performs byte-lane steering for byte, halfword and word transfers, including ARMv4 rotated unaligned word loads.
- Returns a one-cycle ready pulse to the winning requester. The control-store sequencer uses this pulse as its memory-ready stall release.

Parameters:
- FAIR, 1: 1 = alternate grants when both requesters are pending; 0 = data requester always wins.
- TIMEOUT, 255: max cycles waiting for mem_ack before the access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_req  in  1  fetch request; held high with stable if_addr until if_rdy
- if_addr  in  32  fetch byte address
- if_rdy  out  1  one-cycle fetch completion pulse
- if_rdata  out  32  fetched word; valid while if_rdy=1
- if_abort  out  1  fetch timed out; valid with if_rdy
- d_req  in  1  data request; held high with stable fields until d_rdy
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-justified
- d_rdy  out  1  one-cycle data completion pulse
- d_rdata  out  32  load result; valid while d_rdy=1
- d_abort  out  1  data access timed out; valid with d_rdy
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_be  out  4  byte enables
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_wdata  out  32  lane-steered write data
- mem_ack  in  1  memory completion, sampled while mem_req=1
- mem_rdata  in  32  read data; valid with mem_ack
- busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
- During and after reset, all outputs are 0, the FSM is in IDLE, the timeout counter is 0 and last_grant = data, so the first tie goes to fetch when FAIR=1.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - if_req or d_req high at a clock edge -> ACCESS.
  - Only one pending: grant that requester.
  - Both pending, FAIR=1: grant the requester opposite to last_grant.
  - Both pending, FAIR=0: grant data.
  - On grant: latch the granted request fields, set mem_req=1, update last_grant.
- ACCESS:
  - mem_req stays 1 and all mem_* outputs stay stable.
  - mem_ack=1 at an edge: latch the steered read data, drop mem_req, -> RESP.
  - The timeout counter increments each ACCESS cycle without ack.
  - Counter reaching TIMEOUT (TIMEOUT != 0): drop mem_req, set abort for the granted requester, rdata = 0, -> RESP.
  - ack and timeout at the same edge: ack wins, no abort.
- RESP:
  - Exactly one cycle with the granted requester's rdy=1, its rdata and abort valid.
  - -> IDLE; the counter clears.
  - The requester deasserts req at the edge ending the rdy cycle.
  - rdata and abort return to 0 when rdy falls.
- Latency: req sampled in IDLE at edge E0 -> mem_req high after E0.
  - Zero-wait ack -> rdy high for the cycle after the next edge.
  - Minimum request-to-rdy is 2 cycles.
  - Back-to-back throughput is one access per 3 cycles minimum.
- Byte lanes for stores, with a = addr[1:0]:
  - byte: be = 1<<a, wdata = byte replicated into all 4 lanes.
  - half: be = a[1] ? 1100 : 0011, halfword replicated into both halves; addr[0] is ignored.
  - word: be = 1111, wdata unmodified; a is ignored.
- Loads:
  - mem_be = 1111 for all loads.
  - byte: zero-extended lane a.
  - half: zero-extended half a[1].
  - word: mem_rdata rotated right by 8*a (ARMv4 LDR rotation).
  - Sign extension is the datapath's job.
- Fetch: always a word read, be = 1111, no rotation.
- mem_ack outside ACCESS is ignored, including a late ack after a timeout.
- Requests arriving while busy wait; they are never dropped.
- rst asserted in any state returns the FSM to IDLE at that edge, with mem_req=0 and no rdy pulse; a pending transaction is discarded.
- Deasserting req before rdy is illegal; the bench flags it and the behaviour is undefined.

Test Plan:
- Single fetch: if_addr=0x100, mem_ack one cycle after mem_req, mem_rdata=0xE3A01005 -> mem_addr=0x100, be=1111, if_rdy pulse 2 cycles after request with if_rdata=0xE3A01005.
- Contention with FAIR=1: if_req and d_req both high from reset, zero-wait ack -> grant order fetch, data, fetch, data; each rdy exactly one cycle; no request is lost.
- Store byte: d_addr=0x203, d_wdata=0x000000AB -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x200, mem_we=1.
- Load byte: d_addr=0x202 with mem_rdata=0x11223344 -> d_rdata=0x00000022.
- Unaligned word load: d_addr=0x301, mem_rdata=0x11223344 -> d_rdata=0x44112233.
- Timeout: TIMEOUT=4, mem_ack held low -> mem_req drops after 4 ACCESS cycles, then d_rdy=1, d_abort=1, d_rdata=0; a later stray mem_ack is ignored.
- Reset mid-access: rst asserted in ACCESS -> mem_req=0 and busy=0 next cycle, no rdy pulse; a fresh request is then served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter for the ARMv4 fetch and load/store requesters.
// Request/ack sequencing, byte-lane steering and one-cycle ready pulses.
module mem_port_arbiter #(
    parameter int FAIR    = 1,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_rdy,
    output logic [31:0] if_rdata,
    output logic        if_abort,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_rdy,
    output logic [31:0] d_rdata,
    output logic        d_abort,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    state_t        state, state_n;
    logic          grant_d, grant_n;
    logic          last_d, last_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [1:0]    size_l, size_n;
    logic [1:0]    lane_l, lane_n;

    logic          mem_req_n, mem_we_n;
    logic [3:0]    mem_be_n;
    logic [31:0]   mem_addr_n, mem_wdata_n;
    logic          if_rdy_n, if_abort_n, d_rdy_n, d_abort_n;
    logic [31:0]   if_rdata_n, d_rdata_n;
    logic          busy_n;

    logic          pick_d, timed_out;
    logic [31:0]   rd_steer;
    logic          unused_bits;

    function automatic logic [3:0] store_be(input logic [1:0] sz,
                                            input logic [1:0] a);
        logic [3:0] r;
        unique case (sz)
            2'b00:   r = 4'b0001 << a;
            2'b01:   r = a[1] ? 4'b1100 : 4'b0011;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] sz,
                                               input logic [31:0] w);
        logic [31:0] r;
        unique case (sz)
            2'b00:   r = {4{w[7:0]}};
            2'b01:   r = {2{w[15:0]}};
            default: r = w;
        endcase
        return r;
    endfunction

    // Word loads rotate right by the byte offset, as ARMv4 LDR does.
    function automatic logic [31:0] load_data(input logic [1:0] sz,
                                              input logic [1:0] a,
                                              input logic [31:0] rd);
        logic [31:0] r;
        unique case (sz)
            2'b00: begin
                unique case (a)
                    2'b00:   r = {24'h0, rd[7:0]};
                    2'b01:   r = {24'h0, rd[15:8]};
                    2'b10:   r = {24'h0, rd[23:16]};
                    default: r = {24'h0, rd[31:24]};
                endcase
            end
            2'b01: r = a[1] ? {16'h0, rd[31:16]} : {16'h0, rd[15:0]};
            default: begin
                unique case (a)
                    2'b00:   r = rd;
                    2'b01:   r = {rd[7:0], rd[31:8]};
                    2'b10:   r = {rd[15:0], rd[31:16]};
                    default: r = {rd[23:0], rd[31:24]};
                endcase
            end
        endcase
        return r;
    endfunction

    assign unused_bits = ^if_addr[1:0];

    // On a tie, fairness hands the port to whoever did not win last time.
    assign pick_d    = d_req && (!if_req || (FAIR == 0) || !last_d);
    assign cnt_inc   = cnt + CW'(1);
    assign timed_out = (TIMEOUT != 0) && (cnt_inc == TMAX);
    assign rd_steer  = !grant_d ? mem_rdata :
                       mem_we   ? 32'h0 :
                       load_data(size_l, lane_l, mem_rdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_d   <= 1'b0;
            last_d    <= 1'b1;
            cnt       <= '0;
            size_l    <= 2'b00;
            lane_l    <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            if_rdy    <= 1'b0;
            if_rdata  <= 32'h0;
            if_abort  <= 1'b0;
            d_rdy     <= 1'b0;
            d_rdata   <= 32'h0;
            d_abort   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            grant_d   <= grant_n;
            last_d    <= last_n;
            cnt       <= cnt_n;
            size_l    <= size_n;
            lane_l    <= lane_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_be    <= mem_be_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            if_rdy    <= if_rdy_n;
            if_rdata  <= if_rdata_n;
            if_abort  <= if_abort_n;
            d_rdy     <= d_rdy_n;
            d_rdata   <= d_rdata_n;
            d_abort   <= d_abort_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        grant_n     = grant_d;
        last_n      = last_d;
        cnt_n       = cnt;
        size_n      = size_l;
        lane_n      = lane_l;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_be_n    = mem_be;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        if_rdy_n    = 1'b0;
        if_rdata_n  = 32'h0;
        if_abort_n  = 1'b0;
        d_rdy_n     = 1'b0;
        d_rdata_n   = 32'h0;
        d_abort_n   = 1'b0;

        unique case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    state_n   = ACCESS;
                    grant_n   = pick_d;
                    last_n    = pick_d;
                    cnt_n     = '0;
                    mem_req_n = 1'b1;
                    if (pick_d) begin
                        size_n      = d_size;
                        lane_n      = d_addr[1:0];
                        mem_we_n    = d_we;
                        mem_addr_n  = {d_addr[31:2], 2'b00};
                        mem_be_n    = d_we ? store_be(d_size, d_addr[1:0])
                                           : 4'b1111;
                        mem_wdata_n = d_we ? store_data(d_size, d_wdata)
                                           : 32'h0;
                    end else begin
                        size_n      = 2'b10;
                        lane_n      = 2'b00;
                        mem_we_n    = 1'b0;
                        mem_addr_n  = {if_addr[31:2], 2'b00};
                        mem_be_n    = 4'b1111;
                        mem_wdata_n = 32'h0;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack || timed_out) begin
                    state_n     = RESP;
                    mem_req_n   = 1'b0;
                    mem_we_n    = 1'b0;
                    mem_be_n    = 4'h0;
                    mem_addr_n  = 32'h0;
                    mem_wdata_n = 32'h0;
                    if (grant_d) begin
                        d_rdy_n    = 1'b1;
                        d_rdata_n  = mem_ack ? rd_steer : 32'h0;
                        d_abort_n  = !mem_ack;
                    end else begin
                        if_rdy_n   = 1'b1;
                        if_rdata_n = mem_ack ? rd_steer : 32'h0;
                        if_abort_n = !mem_ack;
                    end
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            RESP: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration, lane steering,
// timeout abort and reset recovery with hand-computed expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rdy;
    logic [31:0] if_rdata;
    logic        if_abort;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_rdy;
    logic [31:0] d_rdata;
    logic        d_abort;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    logic        ack_en;
    logic        ack_force;
    logic [31:0] rsp_data;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.FAIR(1), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdy(if_rdy),
        .if_rdata(if_rdata), .if_abort(if_abort),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdy(d_rdy), .d_rdata(d_rdata),
        .d_abort(d_abort),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Zero-wait memory: acks in the first cycle it sees mem_req.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ack   = ack_force || (ack_en && mem_req);
            mem_rdata = rsp_data;
        end
    end

    task automatic idle_inputs();
        if_req  = 1'b0;
        if_addr = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_size  = 2'b00;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
    endtask

    task automatic wait_rdy(output logic gi, output logic gd,
                            output int cyc);
        gi  = 1'b0;
        gd  = 1'b0;
        cyc = 0;
        while (!gi && !gd && cyc < 12) begin
            @(negedge clk);
            cyc++;
            gi = if_rdy;
            gd = d_rdy;
        end
    endtask

    task automatic test_reset();
        logic [6:0] flags;
        rst       = 1'b1;
        ack_en    = 1'b1;
        ack_force = 1'b0;
        rsp_data  = 32'h0;
        idle_inputs();
        repeat (3) @(negedge clk);
        flags = {if_rdy, if_abort, d_rdy, d_abort, mem_req, mem_we, busy};
        n_cmp++;
        if (flags !== 7'h0) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 0000000", flags);
        end
        n_cmp++;
        if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 128'h0) begin
            n_bad++;
            $display("FAIL reset_data got %h %h %h %h want 0",
                     if_rdata, d_rdata, mem_addr, mem_wdata);
        end
        n_cmp++;
        if (mem_be !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_be got %b want 0000", mem_be);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_single_fetch();
        rsp_data = 32'hE3A01005;
        @(negedge clk);
        if_addr = 32'h100;
        if_req  = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, mem_we, busy, if_rdy} !== 4'b1010) begin
            n_bad++;
            $display("FAIL fetch_req req/we/busy/rdy got %b want 1010",
                     {mem_req, mem_we, busy, if_rdy});
        end
        n_cmp++;
        if (mem_addr !== 32'h100 || mem_be !== 4'b1111) begin
            n_bad++;
            $display("FAIL fetch_addr got %h/%b want 00000100/1111",
                     mem_addr, mem_be);
        end
        @(negedge clk);
        n_cmp++;
        if ({if_rdy, if_abort, d_rdy} !== 3'b100) begin
            n_bad++;
            $display("FAIL fetch_rdy rdy/abort/d_rdy got %b want 100",
                     {if_rdy, if_abort, d_rdy});
        end
        n_cmp++;
        if (if_rdata !== 32'hE3A01005) begin
            n_bad++;
            $display("FAIL fetch_rdata got %h want e3a01005", if_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (if_rdy !== 1'b0 || if_rdata !== 32'h0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_after rdy %b rdata %h busy %b want 0 0 0",
                     if_rdy, if_rdata, busy);
        end
    endtask

    task automatic test_contention();
        logic gi, gd;
        int   cyc;
        logic want_if;
        rst     = 1'b1;
        if_addr = 32'h500;
        if_req  = 1'b1;
        d_addr  = 32'h600;
        d_size  = 2'b10;
        d_we    = 1'b0;
        d_req   = 1'b1;
        rsp_data = 32'hA5A50000;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL cont_in_reset req %b busy %b want 0 0",
                     mem_req, busy);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            want_if = (k % 2 == 0);
            wait_rdy(gi, gd, cyc);
            n_cmp++;
            if (gi !== want_if || gd !== !want_if || cyc != 2) begin
                n_bad++;
                $display("FAIL cont_grant%0d if/d/cyc got %b%b/%0d want %b%b/2",
                         k, gi, gd, cyc, want_if, !want_if);
            end
            n_cmp++;
            if (want_if && if_rdata !== 32'hA5A50000 + k) begin
                n_bad++;
                $display("FAIL cont_data%0d if_rdata got %h want %h",
                         k, if_rdata, 32'hA5A50000 + k);
            end else if (!want_if && d_rdata !== 32'hA5A50000 + k) begin
                n_bad++;
                $display("FAIL cont_data%0d d_rdata got %h want %h",
                         k, d_rdata, 32'hA5A50000 + k);
            end
            rsp_data = 32'hA5A50000 + k + 1;
            if (k == 3) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
            @(negedge clk);
            n_cmp++;
            if (if_rdy !== 1'b0 || d_rdy !== 1'b0) begin
                n_bad++;
                $display("FAIL cont_pulse%0d rdy stayed high if %b d %b",
                         k, if_rdy, d_rdy);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL cont_end busy %b req %b want 0 0", busy, mem_req);
        end
    endtask

    task automatic test_store_lanes();
        logic [31:0] va[5] = '{32'h203, 32'h202, 32'h201, 32'h102, 32'h100};
        logic [1:0]  vs[5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
        logic [31:0] vw[5] = '{32'h000000AB, 32'h1234CDEF, 32'h00005678,
                               32'hDEADBEEF, 32'h01020304};
        logic [3:0]  eb[5] = '{4'b1000, 4'b1100, 4'b0011, 4'b1111, 4'b1111};
        logic [31:0] ew[5] = '{32'hABABABAB, 32'hCDEFCDEF, 32'h56785678,
                               32'hDEADBEEF, 32'h01020304};
        logic [31:0] ea[5] = '{32'h200, 32'h200, 32'h200, 32'h100, 32'h100};
        logic gi, gd;
        int   cyc;
        rsp_data = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            d_we    = 1'b1;
            d_size  = vs[i];
            d_addr  = va[i];
            d_wdata = vw[i];
            d_req   = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ea[i]) begin
                n_bad++;
                $display("FAIL store%0d req/we/addr got %b%b/%h want 11/%h",
                         i, mem_req, mem_we, mem_addr, ea[i]);
            end
            n_cmp++;
            if (mem_be !== eb[i] || mem_wdata !== ew[i]) begin
                n_bad++;
                $display("FAIL store%0d be/wdata got %b/%h want %b/%h",
                         i, mem_be, mem_wdata, eb[i], ew[i]);
            end
            wait_rdy(gi, gd, cyc);
            n_cmp++;
            if (gd !== 1'b1 || gi !== 1'b0 || cyc != 1 || d_abort !== 1'b0) begin
                n_bad++;
                $display("FAIL store%0d done d/if/cyc/abort got %b%b/%0d/%b want 10/1/0",
                         i, gd, gi, cyc, d_abort);
            end
            d_req = 1'b0;
            d_we  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_load_lanes();
        logic [31:0] va[8] = '{32'h202, 32'h203, 32'h200, 32'h302,
                               32'h301, 32'h301, 32'h302, 32'h303};
        logic [1:0]  vs[8] = '{2'b00, 2'b00, 2'b00, 2'b01,
                               2'b01, 2'b10, 2'b10, 2'b11};
        logic [31:0] er[8] = '{32'h00000022, 32'h00000011, 32'h00000044,
                               32'h00001122, 32'h00003344, 32'h44112233,
                               32'h33441122, 32'h22334411};
        logic gi, gd;
        int   cyc;
        rsp_data = 32'h11223344;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            d_we   = 1'b0;
            d_size = vs[i];
            d_addr = va[i];
            d_req  = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (mem_be !== 4'b1111 || mem_we !== 1'b0 ||
                mem_addr !== {va[i][31:2], 2'b00}) begin
                n_bad++;
                $display("FAIL load%0d be/we/addr got %b/%b/%h want 1111/0/%h",
                         i, mem_be, mem_we, mem_addr, {va[i][31:2], 2'b00});
            end
            wait_rdy(gi, gd, cyc);
            n_cmp++;
            if (gd !== 1'b1 || d_rdata !== er[i] || d_abort !== 1'b0) begin
                n_bad++;
                $display("FAIL load%0d rdy/rdata/abort got %b/%h/%b want 1/%h/0",
                         i, gd, d_rdata, d_abort, er[i]);
            end
            d_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        int   n_req;
        logic seen;
        ack_en   = 1'b0;
        rsp_data = 32'h5A5A5A5A;
        n_req    = 0;
        seen     = 1'b0;
        @(negedge clk);
        d_we   = 1'b0;
        d_size = 2'b10;
        d_addr = 32'h400;
        d_req  = 1'b1;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (mem_req) n_req++;
            seen = d_rdy;
        end
        n_cmp++;
        if (!seen || n_req != 4) begin
            n_bad++;
            $display("FAIL timeout_len rdy %b req cycles %0d want 1 4",
                     seen, n_req);
        end
        n_cmp++;
        if (d_abort !== 1'b1 || d_rdata !== 32'h0 || mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_abort abort/rdata/req got %b/%h/%b want 1/0/0",
                     d_abort, d_rdata, mem_req);
        end
        d_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (d_abort !== 1'b0 || d_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_clear abort %b rdy %b want 0 0",
                     d_abort, d_rdy);
        end
        ack_force = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, d_rdy, if_rdy, mem_req, d_abort} !== 5'b0) begin
            n_bad++;
            $display("FAIL stray_ack busy/d/if/req/abort got %b want 00000",
                     {busy, d_rdy, if_rdy, mem_req, d_abort});
        end
        ack_force = 1'b0;
        repeat (2) @(negedge clk);
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic gi, gd;
        int   cyc;
        ack_en = 1'b0;
        @(negedge clk);
        if_addr = 32'h704;
        if_req  = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pre req %b busy %b want 1 1", mem_req, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({mem_req, busy, if_rdy, if_abort} !== 4'b0) begin
            n_bad++;
            $display("FAIL rstmid_clear req/busy/rdy/abort got %b want 0000",
                     {mem_req, busy, if_rdy, if_abort});
        end
        rst      = 1'b0;
        rsp_data = 32'h0BADF00D;
        ack_en   = 1'b1;
        wait_rdy(gi, gd, cyc);
        n_cmp++;
        if (gi !== 1'b1 || cyc != 2 || if_rdata !== 32'h0BADF00D ||
            if_abort !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_fresh rdy/cyc/rdata/abort got %b/%0d/%h/%b want 1/2/0badf00d/0",
                     gi, cyc, if_rdata, if_abort);
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_store_lanes();
        test_load_lanes();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
